// File: rtl/lif_tm_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire frame sequencer: one neuron per cycle,
// per-neuron membrane/threshold/leak storage, spike indices queued to a valid/ready consumer.
module lif_tm_scheduler #(
    parameter int NEURONS   = 8,
    parameter int IDX_W     = 3,
    parameter int EVQ_DEPTH = 4,
    parameter int THR_RST   = 127,
    parameter int LEAK_RST  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    output logic [IDX_W-1:0]   cur_idx,
    input  logic [7:0]         cur_data,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [7:0]         cfg_data,
    output logic               cfg_err,
    output logic               busy,
    output logic               frame_done,
    output logic               tick_overrun,
    output logic [NEURONS-1:0] spike_vec,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_idx
);

    localparam int QA_W = $clog2(EVQ_DEPTH);
    localparam logic [QA_W:0]      Q_FULL   = (QA_W+1)'(EVQ_DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NEURONS - 1);
    localparam logic [7:0]         THR_INIT = 8'(THR_RST);
    localparam logic [2:0]         LEAK_INIT = 3'(LEAK_RST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DONE} state_t;

    state_t             r_fsm;
    logic [IDX_W-1:0]   r_idx;
    logic [NEURONS-1:0] r_acc;
    logic [NEURONS-1:0] r_spike_vec;
    logic               r_cfg_err;
    logic               r_frame_done;
    logic               r_tick_overrun;

    logic [7:0]         r_mem  [NEURONS];
    logic [7:0]         r_thr  [NEURONS];
    logic [2:0]         r_leak [NEURONS];

    logic [IDX_W-1:0]   r_q [EVQ_DEPTH];
    logic [QA_W-1:0]    r_wp;
    logic [QA_W-1:0]    r_rp;
    logic [QA_W:0]      r_cnt;

    logic               w_busy;
    logic               w_full;
    logic [7:0]         w_sum;
    logic               w_fire;
    logic               w_proc;
    logic               w_push;
    logic               w_pop;
    logic [NEURONS-1:0] w_acc_nxt;

    // 9-bit unsigned add clipped to 8 bits; keeps membrane state from wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        w_busy    = (r_fsm != S_IDLE);
        w_full    = (r_cnt == Q_FULL);
        w_sum     = sat_add8(cur_data, r_mem[r_idx] >> r_leak[r_idx]);
        w_fire    = (w_sum >= r_thr[r_idx]);
        w_proc    = (r_fsm == S_RUN) && !w_full;
        w_push    = w_proc && w_fire;
        w_pop     = (r_cnt != '0) && evt_ready;
        w_acc_nxt = r_acc;
        if (w_fire) w_acc_nxt = r_acc | (NEURONS'(1) << r_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm          <= S_IDLE;
            r_idx          <= '0;
            r_acc          <= '0;
            r_spike_vec    <= '0;
            r_cfg_err      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_tick_overrun <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_tick_overrun <= tick && w_busy;
            r_cfg_err      <= cfg_we && w_busy;
            case (r_fsm)
                S_IDLE: begin
                    if (tick) begin
                        r_fsm <= S_RUN;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    // Full is judged on start-of-cycle occupancy, so a same-cycle pop still stalls.
                    if (w_full) begin
                        r_fsm <= S_STALL;
                    end else begin
                        r_acc <= w_acc_nxt;
                        if (r_idx == LAST_IDX) begin
                            r_fsm        <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_spike_vec  <= w_acc_nxt;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_STALL: begin
                    if (!w_full) r_fsm <= S_RUN;
                end
                S_DONE: begin
                    r_fsm <= S_IDLE;
                    r_idx <= '0;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                r_mem[i]  <= '0;
                r_thr[i]  <= THR_INIT;
                r_leak[i] <= LEAK_INIT;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (cfg_we && !w_busy) begin
                if (cfg_sel) r_leak[cfg_addr] <= cfg_data[2:0];
                else         r_thr[cfg_addr]  <= cfg_data;
            end
            if (w_proc) r_mem[r_idx] <= w_fire ? 8'd0 : w_sum;
            if (w_push) r_wp <= r_wp + QA_W'(1);
            if (w_pop)  r_rp <= r_rp + QA_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (QA_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (QA_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Queue payload needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wp] <= r_idx;
    end

    assign cur_idx      = r_idx;
    assign busy         = w_busy;
    assign cfg_err      = r_cfg_err;
    assign frame_done   = r_frame_done;
    assign tick_overrun = r_tick_overrun;
    assign spike_vec    = r_spike_vec;
    assign evt_valid    = (r_cnt != '0);
    assign evt_idx      = r_q[r_rp];

endmodule
